// File: rtl/serial_pkg.sv
// Shared definitions for the serial byte link (receiver and matching transmitter).
package serial_pkg;

    localparam int DATA_BITS_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DATA      = 2'd1,
        STOP      = 2'd2,
        WAIT_HIGH = 2'd3
    } rx_state_t;

endpackage

// File: rtl/rx_shift.sv
// Serial-in/parallel-out register: new bit enters at the MSB and the word moves toward the LSB,
// so after DATA_BITS shifts an LSB-first stream sits in natural bit order.
module rx_shift #(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 shift_en,
    input  logic                 din,
    output logic [DATA_BITS-1:0] data
);

    logic [DATA_BITS-1:0] sr_q;
    logic [DATA_BITS-1:0] sr_d;

    generate
        if (DATA_BITS == 1) begin : g_single
            always_comb begin
                sr_d = sr_q;
                if (shift_en) sr_d = din;
            end
        end else begin : g_multi
            always_comb begin
                sr_d = sr_q;
                if (shift_en) sr_d = {din, sr_q[DATA_BITS-1:1]};
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sr_q <= '0;
        else     sr_q <= sr_d;
    end

    assign data = sr_q;

endmodule

// File: rtl/serial_byte_receiver.sv
// Tick-sampled asynchronous-style byte receiver with a valid/ready output register,
// single-cycle framing-error pulse and a sticky overrun flag.
module serial_byte_receiver
    import serial_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_DEFAULT
) (
    input  logic                 c,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 i,
    input  logic                 ready,
    output logic [DATA_BITS-1:0] q,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int               CNT_W    = $clog2(DATA_BITS) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

    rx_state_t            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DATA_BITS-1:0] q_q, q_d;
    logic                 valid_q, valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
    logic [DATA_BITS-1:0] sr;
    logic                 shift_en;
    logic                 stop_tick;
    logic                 load;

    rx_shift #(.DATA_BITS(DATA_BITS)) u_shift (
        .clk      (c),
        .rst      (rst),
        .shift_en (shift_en),
        .din      (i),
        .data     (sr)
    );

    always_ff @(posedge c or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (tick) begin
            case (state_q)
                IDLE:      if (!i) state_d = DATA;
                DATA:      if (cnt_q == LAST_BIT) state_d = STOP;
                STOP:      state_d = i ? IDLE : WAIT_HIGH;
                WAIT_HIGH: if (i) state_d = IDLE;
                default:   state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_d     = cnt_q;
        shift_en  = 1'b0;
        stop_tick = (state_q == STOP) && tick;
        // A completed byte may replace q only if q is empty or being consumed on this same edge.
        load      = stop_tick && i && (!valid_q || ready);

        if (tick && (state_q == IDLE) && !i) cnt_d = '0;
        if (tick && (state_q == DATA)) begin
            shift_en = 1'b1;
            cnt_d    = cnt_q + CNT_W'(1);
        end

        q_d = load ? sr : q_q;
        if (load)                 valid_d = 1'b1;
        else if (valid_q && ready) valid_d = 1'b0;
        else                      valid_d = valid_q;

        overrun_d   = overrun_q | (stop_tick && i && !load);
        frame_err_d = stop_tick && !i;
    end

    always_ff @(posedge c or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            q_q         <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            q_q         <= q_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign q         = q_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_serial_byte_receiver.sv
// Directed bench for serial_byte_receiver: one tick every 4 clocks, frames driven LSB-first.
module tb_serial_byte_receiver;

    logic       c = 1'b0;
    logic       rst;
    logic       tick;
    logic       i_s;
    logic       ready;
    logic [7:0] q;
    logic       valid;
    logic       frame_err;
    logic       overrun;

    int n_checks = 0;
    int n_pass   = 0;

    serial_byte_receiver #(.DATA_BITS(8)) dut (
        .c         (c),
        .rst       (rst),
        .tick      (tick),
        .i         (i_s),
        .ready     (ready),
        .q         (q),
        .valid     (valid),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 c = ~c;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge c);
        #1;
    endtask

    task automatic send_bit(input logic b);
        i_s  = b;
        tick = 1'b1;
        step();
        tick = 1'b0;
        repeat (3) step();
    endtask

    task automatic send_data(input logic [7:0] d);
        send_bit(1'b0);
        for (int k = 0; k < 8; k++) send_bit(d[k]);
    endtask

    // Only the sampling edge of the stop bit; the caller checks right after it.
    task automatic send_stop(input logic b, input logic rdy, input logic [7:0] d);
        i_s   = b;
        ready = rdy;
        tick  = 1'b1;
        step();
        tick  = 1'b0;
        $display("frame 0x%02h stop=%0d ready=%0d -> q=0x%02h valid=%0d ferr=%0d ovr=%0d",
                 d, b, rdy, q, valid, frame_err, overrun);
    endtask

    task automatic idle(input int n);
        i_s = 1'b1;
        repeat (n) step();
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; i_s = 1'b1; ready = 1'b0;
        repeat (2) step();
        check("rst_q", q, 8'h00);
        check("rst_valid", valid, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_ovr", overrun, 0);
        rst = 1'b0;
        idle(3);

        // Basic frame with consumer always ready
        ready = 1'b1;
        send_data(8'h4A);
        send_stop(1'b1, 1'b1, 8'h4A);
        check("t1_valid", valid, 1);
        check("t1_q", q, 8'h4A);
        check("t1_ferr", frame_err, 0);
        step();
        check("t1_valid_pulse", valid, 0);
        check("t1_q_hold", q, 8'h4A);
        idle(3);

        // Framing error, line held low, then recovery
        send_data(8'hFF);
        send_stop(1'b0, 1'b1, 8'hFF);
        check("t3_ferr", frame_err, 1);
        check("t3_valid", valid, 0);
        check("t3_q", q, 8'h4A);
        step();
        check("t3_ferr_pulse", frame_err, 0);
        repeat (3) send_bit(1'b0);
        send_bit(1'b1);
        check("t3_wait_valid", valid, 0);
        ready = 1'b0;
        send_data(8'h12);
        send_stop(1'b1, 1'b0, 8'h12);
        check("t3_next_q", q, 8'h12);
        check("t3_next_valid", valid, 1);
        check("t3_next_ovr", overrun, 0);
        ready = 1'b1;
        step();
        ready = 1'b0;
        check("t3_consumed", valid, 0);
        idle(3);

        // Consume and reload on the same edge
        send_data(8'h10);
        send_stop(1'b1, 1'b0, 8'h10);
        idle(2);
        check("t5_first_valid", valid, 1);
        check("t5_first_q", q, 8'h10);
        send_data(8'h20);
        send_stop(1'b1, 1'b1, 8'h20);
        check("t5_q", q, 8'h20);
        check("t5_valid", valid, 1);
        check("t5_ovr", overrun, 0);
        step();
        ready = 1'b0;
        check("t5_consumed", valid, 0);
        check("t5_q_hold", q, 8'h20);
        idle(3);

        // Overrun: second byte arrives while first is unconsumed
        send_data(8'h55);
        send_stop(1'b1, 1'b0, 8'h55);
        idle(3);
        check("t2_valid", valid, 1);
        check("t2_q", q, 8'h55);
        check("t2_ovr_before", overrun, 0);
        send_data(8'hA3);
        send_stop(1'b1, 1'b0, 8'hA3);
        check("t2_q_kept", q, 8'h55);
        check("t2_valid_kept", valid, 1);
        check("t2_ovr", overrun, 1);
        ready = 1'b1;
        step();
        ready = 1'b0;
        check("t2_consumed", valid, 0);
        check("t2_ovr_sticky", overrun, 1);
        idle(3);

        // Asynchronous reset during data bit 4
        begin
            logic [7:0] d;
            d = 8'hC3;
            send_bit(1'b0);
            for (int k = 0; k < 4; k++) send_bit(d[k]);
            i_s  = d[4];
            tick = 1'b1;
            @(posedge c);
            #2;
            rst = 1'b1;
            #1;
            check("t4_rst_q", q, 8'h00);
            check("t4_rst_valid", valid, 0);
            check("t4_rst_ferr", frame_err, 0);
            check("t4_rst_ovr", overrun, 0);
            tick = 1'b0;
            step();
            rst = 1'b0;
            $display("reset applied mid-frame of 0x%02h", d);
        end
        idle(3);
        send_data(8'h3C);
        send_stop(1'b1, 1'b0, 8'h3C);
        check("t4_q", q, 8'h3C);
        check("t4_valid", valid, 1);
        ready = 1'b1;
        step();
        ready = 1'b0;
        idle(3);

        // Idle line with a glitch outside tick cycles
        repeat (20) send_bit(1'b1);
        check("t6_idle_valid", valid, 0);
        i_s = 1'b0;
        repeat (2) step();
        i_s = 1'b1;
        idle(2);
        send_bit(1'b1);
        check("t6_glitch_valid", valid, 0);
        send_data(8'h81);
        send_stop(1'b1, 1'b0, 8'h81);
        check("t6_q", q, 8'h81);
        check("t6_valid", valid, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
